// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin shared Gray/binary converter with valid/ready response
module gray_conv_arbiter #(
    parameter int DATA_WID = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic                req0_dir,
    input  logic [DATA_WID-1:0] req0_data,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic                req1_dir,
    input  logic [DATA_WID-1:0] req1_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [DATA_WID-1:0] rsp_data
);
    typedef enum logic {IDLE, RESP} state_t;
    state_t state, state_nxt;
    logic last_grant, gnt_id, accept, sel_dir;
    logic [DATA_WID-1:0] sel_data, conv;

    function automatic logic [DATA_WID-1:0] gray2bin(input logic [DATA_WID-1:0] g);
        logic [DATA_WID-1:0] b;
        for (int i = 0; i < DATA_WID; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    always_comb begin
        gnt_id     = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        accept     = rst_n && state == IDLE && (req0_valid || req1_valid);
        req0_ready = accept && !gnt_id;
        req1_ready = accept && gnt_id;
        sel_dir    = gnt_id ? req1_dir : req0_dir;
        sel_data   = gnt_id ? req1_data : req0_data;
        conv       = sel_dir ? (sel_data ^ (sel_data >> 1)) : gray2bin(sel_data);
        rsp_valid  = state == RESP;
        state_nxt  = state == IDLE ? (accept ? RESP : IDLE) : (rsp_ready ? IDLE : RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                last_grant <= gnt_id;
                rsp_id     <= gnt_id;
                rsp_data   <= conv;
            end
        end
    end
endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb_gray_conv_arbiter: directed checks of arbitration, conversion, backpressure and reset
module tb_gray_conv_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic req0_valid, req0_ready, req0_dir;
    logic req1_valid, req1_ready, req1_dir;
    logic [3:0] req0_data, req1_data, rsp_data;
    logic rsp_valid, rsp_ready, rsp_id;
    int total = 0;
    int bad = 0;

    gray_conv_arbiter #(.DATA_WID(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_dir(req0_dir), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_dir(req1_dir), .req1_data(req1_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [3:0] m_g2b(input logic [3:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    function automatic logic [3:0] m_b2g(input logic [3:0] b);
        return {b[3], b[3] ^ b[2], b[2] ^ b[1], b[1] ^ b[0]};
    endfunction

    logic [3:0] r;
    logic exp_id;

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_dir = 1'b0; req0_data = 4'b1011;
        req1_valid = 1'b1; req1_dir = 1'b1; req1_data = 4'b1101;
        @(negedge clk);
        repeat (3) tick();
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);

        rst_n = 1'b1; rsp_ready = 1'b1;
        #1;
        check("first_ready0", req0_ready, 1);
        check("first_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        check("g2b_valid", rsp_valid, 1);
        check("g2b_id", rsp_id, 0);
        check("g2b_data", rsp_data, 8'b1101);
        check("g2b_resp_ready1", req1_ready, 0);
        tick();
        check("b2g_ready1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        check("b2g_id", rsp_id, 1);
        check("b2g_data", rsp_data, 8'b1011);
        tick();
        check("idle_valid", rsp_valid, 0);

        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_id = k[0];
            #1;
            check("rr_ready0", req0_ready, {7'd0, !exp_id});
            check("rr_ready1", req1_ready, {7'd0, exp_id});
            tick();
            check("rr_id", rsp_id, {7'd0, exp_id});
            check("rr_data", rsp_data, exp_id ? 8'b1011 : 8'b1101);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        for (int v = 0; v < 16; v++) begin
            req0_valid = 1'b1; req0_dir = 1'b0; req0_data = 4'(v);
            #1;
            check("sw_g_ready0", req0_ready, 1);
            tick();
            req0_valid = 1'b0;
            check("sw_g2b", rsp_data, {4'd0, m_g2b(4'(v))});
            r = rsp_data;
            tick();
            req1_valid = 1'b1; req1_dir = 1'b1; req1_data = r;
            tick();
            req1_valid = 1'b0;
            check("sw_roundtrip", rsp_data, 8'(v));
            tick();
        end
        for (int v = 0; v < 16; v++) begin
            req1_valid = 1'b1; req1_dir = 1'b1; req1_data = 4'(v);
            tick();
            req1_valid = 1'b0;
            check("sw_b2g_id", rsp_id, 1);
            check("sw_b2g", rsp_data, {4'd0, m_b2g(4'(v))});
            tick();
        end

        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_dir = 1'b0; req0_data = 4'b0110;
        req1_valid = 1'b1; req1_dir = 1'b1; req1_data = 4'b0011;
        #1;
        check("bp_ready0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", rsp_valid, 1);
            check("bp_data", rsp_data, 8'b0100);
            check("bp_id", rsp_id, 0);
            check("bp_ready", {req0_ready, req1_ready}, 0);
            tick();
        end
        rst_n = 1'b0; rsp_ready = 1'b1;
        tick();
        check("rr_rst_valid", rsp_valid, 0);
        check("rr_rst_data", rsp_data, 0);
        check("rr_rst_ready1", req1_ready, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready1", req1_ready, 1);
        check("post_rst_valid", rsp_valid, 0);
        req0_valid = 1'b1;
        #1;
        check("post_rst_contend0", req0_ready, 1);
        check("post_rst_contend1", req1_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
